logic_qspi_pattern_generator: RTL and testbench



---
 rtl/logic_qspi_pattern_generator.sv | 185 ++++++++++++++++++
 tb/tb_logic_qspi_pattern_generator.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_qspi_pattern_generator.sv
// Quad-SPI stimulus transmitter. Byte patterns loaded over the command bus are replayed
// as F preamble nibbles, a 0 start nibble, the data nibbles (high first) and an F tail.
module logic_qspi_pattern_generator #(
   parameter int DEPTH            = 64,
   parameter int HALF_PERIOD      = 2,
   parameter int PREAMBLE_NIBBLES = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       dev_command_started,
   input  logic       dev_command_processing,
   input  logic [4:0] dev_command,
   input  logic       dev_command_data_signal,
   input  logic [7:0] dev_data,
   output logic       dev_busy,
   output logic       qspi_clock,
   output logic [3:0] qspi_data,
   output logic       buffer_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int PW = (PREAMBLE_NIBBLES > 1) ? $clog2(PREAMBLE_NIBBLES) : 1;

   localparam logic [4:0]    QG_CLEAR  = 5'h0;
   localparam logic [4:0]    QG_LOAD   = 5'h1;
   localparam logic [4:0]    QG_SEND   = 5'h2;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [TW-1:0] TICK_LAST = TW'(HALF_PERIOD - 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(PREAMBLE_NIBBLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREAMBLE,
      S_START,
      S_DATA_HI,
      S_DATA_LO,
      S_TAIL
   } tx_state_e;

   tx_state_e     state_q;
   logic          busy_q;
   logic          qspi_clock_q;
   logic [3:0]    qspi_data_q;
   logic          half_q;
   logic [TW-1:0] tick_q;
   logic [PW-1:0] pre_q;
   logic [AW-1:0] rd_idx_q;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_data_q;
   logic [7:0]    mem_q [DEPTH];

   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          load_mode_q, load_mode_d;

   logic cmd_ok, do_clear, do_load, send_any, do_send, wr_req, wr_en;

   // Everything on the command bus is ignored while a transmission is running.
   assign cmd_ok   = dev_command_started && !busy_q;
   assign do_clear = cmd_ok && (dev_command == QG_CLEAR);
   assign do_load  = cmd_ok && (dev_command == QG_LOAD);
   assign send_any = cmd_ok && (dev_command == QG_SEND);
   assign do_send  = send_any && (count_q != '0);

   // A command strobe in the same cycle wins; the data byte is dropped silently.
   assign wr_req = dev_command_data_signal && dev_command_processing && load_mode_q &&
                   !busy_q && !dev_command_started;
   assign wr_en  = wr_req && (count_q != DEPTH_C);

   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
      count_d     = count_q;
      overflow_d  = overflow_q;
      load_mode_d = load_mode_q;
      if (load_mode_q && !dev_command_processing) load_mode_d = 1'b0;
      if (do_clear || send_any) load_mode_d = 1'b0;
      if (do_load) load_mode_d = 1'b1;
      if (do_clear) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (wr_req) begin
         if (count_q == DEPTH_C) overflow_d = 1'b1;
         else                    count_d    = count_q + CW'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         load_mode_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         load_mode_q <= load_mode_d;
      end
   end

   // While in DATA_LO the next byte is prefetched, so it is ready at the nibble boundary.
   assign rd_addr = (state_q == S_DATA_LO) ? rd_idx_q + AW'(1) : rd_idx_q;

   // NOTE: the pattern buffer has no reset so it maps onto block RAM; contents start undefined.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[count_q[AW-1:0]] <= dev_data;
      rd_data_q <= mem_q[rd_addr];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         qspi_clock_q <= 1'b0;
         qspi_data_q  <= 4'hF;
         half_q       <= 1'b0;
         tick_q       <= '0;
         pre_q        <= '0;
         rd_idx_q     <= '0;
      end else if (state_q == S_IDLE) begin
         if (do_send) begin
            state_q      <= S_PREAMBLE;
            busy_q       <= 1'b1;
            qspi_clock_q <= 1'b0;
            qspi_data_q  <= 4'hF;
            half_q       <= 1'b0;
            tick_q       <= '0;
            pre_q        <= '0;
            rd_idx_q     <= '0;
         end
      end else if (tick_q != TICK_LAST) begin
         tick_q <= tick_q + TW'(1);
      end else if (!half_q) begin
         tick_q       <= '0;
         half_q       <= 1'b1;
         qspi_clock_q <= 1'b1;
      end else begin
         // End of a nibble period: next low phase starts with the next nibble on the bus.
         tick_q       <= '0;
         half_q       <= 1'b0;
         qspi_clock_q <= 1'b0;
         case (state_q)
            S_PREAMBLE: begin
               if (pre_q == PRE_LAST) begin
                  state_q     <= S_START;
                  qspi_data_q <= 4'h0;
               end else begin
                  pre_q       <= pre_q + PW'(1);
                  qspi_data_q <= 4'hF;
               end
            end
            S_START: begin
               state_q     <= S_DATA_HI;
               qspi_data_q <= rd_data_q[7:4];
            end
            S_DATA_HI: begin
               state_q     <= S_DATA_LO;
               qspi_data_q <= rd_data_q[3:0];
            end
            S_DATA_LO: begin
               rd_idx_q <= rd_idx_q + AW'(1);
               if ((CW'(rd_idx_q) + CW'(1)) < count_q) begin
                  state_q     <= S_DATA_HI;
                  qspi_data_q <= rd_data_q[7:4];
               end else begin
                  state_q     <= S_TAIL;
                  qspi_data_q <= 4'hF;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               qspi_data_q <= 4'hF;
            end
         endcase
      end
   end

   assign dev_busy        = busy_q;
   assign qspi_clock      = qspi_clock_q;
   assign qspi_data       = qspi_data_q;
   assign buffer_overflow = overflow_q;

endmodule

// File: tb/tb_logic_qspi_pattern_generator.sv
// Randomised self-checking bench: the expected bus stream is built from the byte list
// (preamble, start, nibbles, tail) and compared with nibbles captured on qspi_clock rises.
module tb_logic_qspi_pattern_generator;

   localparam int DEPTH  = 64;
   localparam int HP     = 2;
   localparam int PRE    = 2;
   localparam int B_DEPTH = 16;
   localparam int B_HP   = 1;

   localparam logic [4:0] QG_CLEAR = 5'h0;
   localparam logic [4:0] QG_LOAD  = 5'h1;
   localparam logic [4:0] QG_SEND  = 5'h2;

   typedef logic [3:0] nib_t;
   typedef nib_t       nib_q_t[$];
   typedef logic [7:0] bytes_t[$];

   logic       clock = 1'b0;
   logic       reset_n;
   logic       started, processing, data_sig;
   logic [4:0] command;
   logic [7:0] data;
   logic       busy, qclk, ovf;
   logic [3:0] qdata;

   logic       b_started, b_processing, b_data_sig;
   logic [4:0] b_command;
   logic [7:0] b_data;
   logic       b_busy, b_qclk, b_ovf;
   logic [3:0] b_qdata;

   logic_qspi_pattern_generator #(.DEPTH(DEPTH), .HALF_PERIOD(HP), .PREAMBLE_NIBBLES(PRE)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .dev_command_started(started), .dev_command_processing(processing),
      .dev_command(command), .dev_command_data_signal(data_sig), .dev_data(data),
      .dev_busy(busy), .qspi_clock(qclk), .qspi_data(qdata), .buffer_overflow(ovf)
   );

   // Second instance acts as the loopback source for a fast-clock analyzer capture.
   logic_qspi_pattern_generator #(.DEPTH(B_DEPTH), .HALF_PERIOD(B_HP), .PREAMBLE_NIBBLES(PRE)) u_dut_fast (
      .clock(clock), .reset_n(reset_n),
      .dev_command_started(b_started), .dev_command_processing(b_processing),
      .dev_command(b_command), .dev_command_data_signal(b_data_sig), .dev_data(b_data),
      .dev_busy(b_busy), .qspi_clock(b_qclk), .qspi_data(b_qdata), .buffer_overflow(b_ovf)
   );

   always #5 clock = ~clock;

   int     n_checks = 0;
   int     n_fail   = 0;
   nib_q_t cap_q, b_cap_q;
   int     busy_cycles = 0, b_busy_cycles = 0;
   logic   qclk_prev = 1'b0, b_qclk_prev = 1'b0;
   bytes_t ref_buf;
   logic   ref_ovf;

   // Analyzer-style capture: take the nibble present when the bus clock has just risen.
   always @(negedge clock) begin
      if (qclk === 1'b1 && qclk_prev !== 1'b1) cap_q.push_back(qdata);
      qclk_prev = qclk;
      if (busy === 1'b1) busy_cycles++;
      if (b_qclk === 1'b1 && b_qclk_prev !== 1'b1) b_cap_q.push_back(b_qdata);
      b_qclk_prev = b_qclk;
      if (b_busy === 1'b1) b_busy_cycles++;
   end

   function automatic nib_q_t expected_stream(input bytes_t b);
      nib_q_t q;
      for (int i = 0; i < PRE; i++) q.push_back(4'hF);
      q.push_back(4'h0);
      foreach (b[i]) begin
         q.push_back(b[i][7:4]);
         q.push_back(b[i][3:0]);
      end
      q.push_back(4'hF);
      return q;
   endfunction

   function automatic int expected_busy(input int n_bytes, input int hp);
      return (PRE + 1 + 2 * n_bytes + 1) * 2 * hp;
   endfunction

   function automatic int first_diff(input nib_q_t a, input nib_q_t b);
      int n = (a.size() < b.size()) ? a.size() : b.size();
      for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
      if (a.size() != b.size()) return n;
      return -1;
   endfunction

   function automatic nib_t nib_at(input nib_q_t q, input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return 4'hx;
   endfunction

   function automatic void model_load(input logic [7:0] b);
      if (ref_buf.size() < DEPTH) ref_buf.push_back(b);
      else ref_ovf = 1'b1;
   endfunction

   // All stimulus tasks start and end just after a falling clock edge.
   task automatic pulse_cmd(input logic [4:0] code);
      started = 1'b1;
      command = code;
      @(negedge clock);
      started = 1'b0;
   endtask

   task automatic do_clear();
      pulse_cmd(QG_CLEAR);
      ref_buf.delete();
      ref_ovf = 1'b0;
   endtask

   task automatic load_bytes(input bytes_t b);
      started    = 1'b1;
      command    = QG_LOAD;
      processing = 1'b1;
      @(negedge clock);
      started = 1'b0;
      foreach (b[i]) begin
         data_sig = 1'b1;
         data     = b[i];
         model_load(b[i]);
         @(negedge clock);
         data_sig = 1'b0;
         if ($urandom_range(0, 1) == 1) @(negedge clock);
      end
      processing = 1'b0;
      @(negedge clock);
   endtask

   task automatic send_and_capture(input bit disturb, input bit with_data, input int budget,
                                   output bit first_ok);
      int n = 0;
      cap_q.delete();
      busy_cycles = 0;
      started = 1'b1;
      command = QG_SEND;
      if (with_data) begin
         data_sig = 1'b1;
         data     = 8'h77;
      end
      @(negedge clock);
      started  = 1'b0;
      data_sig = 1'b0;
      first_ok = (busy === 1'b1) && (qclk === 1'b0) && (qdata === 4'hF);
      while (busy === 1'b1 && n < budget) begin
         if (disturb) begin
            case ($urandom_range(0, 3))
               0: begin started = 1'b1; command = 5'($urandom_range(0, 3)); end
               1: begin processing = 1'b1; data_sig = 1'b1; data = 8'($urandom); end
               default: ;
            endcase
         end
         @(negedge clock);
         started  = 1'b0;
         data_sig = 1'b0;
         n++;
      end
      processing = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL send_timeout: dev_busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_checks++;
      if ({busy, qclk, qdata, ovf} !== 7'b0_0_1111_0) begin
         n_fail++;
         $display("FAIL reset_hold: busy/clk/data/ovf=%b/%b/%h/%b expected 0/0/f/0", busy, qclk, qdata, ovf);
      end
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++;
      if ({busy, qclk, qdata, ovf} !== 7'b0_0_1111_0) begin
         n_fail++;
         $display("FAIL reset_release: busy/clk/data/ovf=%b/%b/%h/%b expected 0/0/f/0", busy, qclk, qdata, ovf);
      end
   endtask

   task automatic test_basic();
      bytes_t b;
      nib_q_t exp;
      logic [31:0] word = 32'hFF0A53CF;
      bit first_ok;
      int d;
      for (int i = 7; i >= 0; i--) exp.push_back(word[i*4 +: 4]);
      do_clear();
      b.push_back(8'hA5);
      b.push_back(8'h3C);
      load_bytes(b);
      send_and_capture(1'b0, 1'b0, 200, first_ok);
      n_checks++;
      if (first_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_first_cycle: T+1 busy/clk/data=%b/%b/%h expected 1/0/f at start", busy, qclk, qdata);
      end
      d = first_diff(cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL basic_stream: nibble %0d got %h expected %h (len %0d vs %0d)",
                  d, nib_at(cap_q, d), nib_at(exp, d), cap_q.size(), exp.size());
      end
      n_checks++;
      if (busy_cycles !== 32) begin
         n_fail++;
         $display("FAIL basic_busy_cycles: got %0d expected 32", busy_cycles);
      end
      n_checks++;
      if ({qclk, qdata} !== 5'b0_1111) begin
         n_fail++;
         $display("FAIL basic_idle_after: clk/data=%b/%h expected 0/f", qclk, qdata);
      end
   endtask

   task automatic test_empty_send();
      bit seen_busy = 0, seen_clk = 0, seen_data = 0;
      do_clear();
      pulse_cmd(QG_SEND);
      for (int i = 0; i < 16; i++) begin
         if (busy !== 1'b0) seen_busy = 1;
         if (qclk !== 1'b0) seen_clk = 1;
         if (qdata !== 4'hF) seen_data = 1;
         @(negedge clock);
      end
      n_checks++;
      if (seen_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_busy: dev_busy rose=%b expected 0", seen_busy);
      end
      n_checks++;
      if ({seen_clk, seen_data} !== 2'b00) begin
         n_fail++;
         $display("FAIL empty_bus: clk_toggled/data_changed=%b/%b expected 0/0", seen_clk, seen_data);
      end
   endtask

   task automatic test_overflow();
      bytes_t b;
      nib_q_t exp;
      bit first_ok;
      int d;
      do_clear();
      for (int i = 0; i <= DEPTH; i++) b.push_back(8'(i));
      load_bytes(b);
      n_checks++;
      if (ovf !== ref_ovf) begin
         n_fail++;
         $display("FAIL overflow_set: buffer_overflow=%b expected %b", ovf, ref_ovf);
      end
      send_and_capture(1'b0, 1'b0, 800, first_ok);
      exp = expected_stream(ref_buf);
      d = first_diff(cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL overflow_stream: nibble %0d got %h expected %h (len %0d vs %0d)",
                  d, nib_at(cap_q, d), nib_at(exp, d), cap_q.size(), exp.size());
      end
      n_checks++;
      if (busy_cycles !== expected_busy(DEPTH, HP)) begin
         n_fail++;
         $display("FAIL overflow_busy_cycles: got %0d expected %0d", busy_cycles, expected_busy(DEPTH, HP));
      end
      do_clear();
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear: buffer_overflow=%b expected 0", ovf);
      end
   endtask

   task automatic test_back_to_back();
      bytes_t b;
      nib_q_t exp, first_q;
      bit first_ok;
      int d;
      do_clear();
      b.push_back(8'h12);
      load_bytes(b);
      exp = expected_stream(ref_buf);
      send_and_capture(1'b0, 1'b0, 200, first_ok);
      first_q = cap_q;
      send_and_capture(1'b0, 1'b0, 200, first_ok);
      n_checks++;
      if (first_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_accept: second SEND busy=%b expected 1 on next cycle", busy);
      end
      d = first_diff(first_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL b2b_stream1: nibble %0d got %h expected %h", d, nib_at(first_q, d), nib_at(exp, d));
      end
      d = first_diff(cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL b2b_stream2: nibble %0d got %h expected %h", d, nib_at(cap_q, d), nib_at(exp, d));
      end
   endtask

   task automatic test_priority();
      bytes_t b;
      nib_q_t exp;
      bit first_ok, seen_busy = 0;
      int d;
      // SEND together with a data strobe: the byte is dropped, no overflow.
      do_clear();
      b.push_back(8'($urandom));
      b.push_back(8'($urandom));
      load_bytes(b);
      started    = 1'b1;
      command    = QG_LOAD;
      processing = 1'b1;
      @(negedge clock);
      started = 1'b0;
      send_and_capture(1'b0, 1'b1, 200, first_ok);
      exp = expected_stream(ref_buf);
      d = first_diff(cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL prio_send_stream: nibble %0d got %h expected %h (len %0d vs %0d)",
                  d, nib_at(cap_q, d), nib_at(exp, d), cap_q.size(), exp.size());
      end
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_send_ovf: buffer_overflow=%b expected 0", ovf);
      end
      // CLEAR together with a data strobe: buffer ends up empty.
      started    = 1'b1;
      command    = QG_LOAD;
      processing = 1'b1;
      @(negedge clock);
      started  = 1'b0;
      data_sig = 1'b1;
      data     = 8'h5A;
      @(negedge clock);
      started  = 1'b1;
      command  = QG_CLEAR;
      data     = 8'hC3;
      @(negedge clock);
      started    = 1'b0;
      data_sig   = 1'b0;
      processing = 1'b0;
      ref_buf.delete();
      pulse_cmd(QG_SEND);
      for (int i = 0; i < 12; i++) begin
         if (busy !== 1'b0) seen_busy = 1;
         @(negedge clock);
      end
      n_checks++;
      if (seen_busy !== (ref_buf.size() != 0)) begin
         n_fail++;
         $display("FAIL prio_clear_wins: dev_busy rose=%b expected %b", seen_busy, ref_buf.size() != 0);
      end
   endtask

   task automatic test_reset_mid();
      bytes_t b;
      nib_q_t exp;
      bit first_ok;
      int d;
      do_clear();
      for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
      load_bytes(b);
      pulse_cmd(QG_SEND);
      repeat (13) @(negedge clock);
      reset_n = 1'b0;
      ref_buf.delete();
      ref_ovf = 1'b0;
      #1;
      n_checks++;
      if ({busy, qclk, qdata} !== 6'b0_0_1111) begin
         n_fail++;
         $display("FAIL reset_mid: busy/clk/data=%b/%b/%h expected 0/0/f", busy, qclk, qdata);
      end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      pulse_cmd(QG_SEND);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_count_zero: dev_busy=%b expected 0 for SEND after reset", busy);
      end
      load_bytes(b);
      send_and_capture(1'b0, 1'b0, 300, first_ok);
      exp = expected_stream(ref_buf);
      d = first_diff(cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL reset_replay: nibble %0d got %h expected %h", d, nib_at(cap_q, d), nib_at(exp, d));
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         bytes_t b;
         nib_q_t exp;
         bit first_ok;
         int d;
         int len = $urandom_range(1, 12);
         do_clear();
         for (int i = 0; i < len; i++) b.push_back(8'($urandom));
         load_bytes(b);
         exp = expected_stream(ref_buf);
         for (int pass = 0; pass < 2; pass++) begin
            send_and_capture(pass == 0, 1'b0, 400, first_ok);
            d = first_diff(cap_q, exp);
            n_checks++;
            if (d !== -1) begin
               n_fail++;
               $display("FAIL random_stream it%0d pass%0d: nibble %0d got %h expected %h (len %0d vs %0d)",
                        it, pass, d, nib_at(cap_q, d), nib_at(exp, d), cap_q.size(), exp.size());
            end
            n_checks++;
            if (busy_cycles !== expected_busy(len, HP)) begin
               n_fail++;
               $display("FAIL random_busy it%0d pass%0d: got %0d expected %0d",
                        it, pass, busy_cycles, expected_busy(len, HP));
            end
         end
      end
   endtask

   task automatic test_loopback();
      bytes_t b;
      nib_q_t exp;
      int d, n = 0;
      b_started = 1'b1;
      b_command = QG_CLEAR;
      @(negedge clock);
      b_command  = QG_LOAD;
      b_processing = 1'b1;
      @(negedge clock);
      b_started = 1'b0;
      for (int i = 0; i < 16; i++) begin
         b.push_back(8'(i));
         b_data_sig = 1'b1;
         b_data     = 8'(i);
         @(negedge clock);
      end
      b_data_sig   = 1'b0;
      b_processing = 1'b0;
      @(negedge clock);
      b_cap_q.delete();
      b_busy_cycles = 0;
      b_started = 1'b1;
      b_command = QG_SEND;
      @(negedge clock);
      b_started = 1'b0;
      while (b_busy === 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      exp = expected_stream(b);
      d = first_diff(b_cap_q, exp);
      n_checks++;
      if (d !== -1) begin
         n_fail++;
         $display("FAIL loopback_stream: nibble %0d got %h expected %h (len %0d vs %0d)",
                  d, nib_at(b_cap_q, d), nib_at(exp, d), b_cap_q.size(), exp.size());
      end
      n_checks++;
      if (b_busy_cycles !== expected_busy(16, B_HP)) begin
         n_fail++;
         $display("FAIL loopback_busy: got %0d expected %0d", b_busy_cycles, expected_busy(16, B_HP));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      started = 1'b0; processing = 1'b0; data_sig = 1'b0; command = '0; data = '0;
      b_started = 1'b0; b_processing = 1'b0; b_data_sig = 1'b0; b_command = '0; b_data = '0;
      ref_ovf = 1'b0;
      test_reset();
      test_basic();
      test_empty_send();
      test_overflow();
      test_back_to_back();
      test_priority();
      test_reset_mid();
      test_random();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, limit 500000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
